// File: rtl/clock_group_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : clock_group_reset_sequencer
// Description : Source end of a single-clock group. Forwards the block clock
//               to every member and sequences the member resets: all resets
//               are held for HOLD_CYCLES, then released one member per
//               STAGGER_CYCLES slot in ascending index order. A masked
//               re-reset request replays the same timing for the selected
//               members only.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_group_reset_sequencer #(
  parameter int MEMBERS        = 4,
  parameter int HOLD_CYCLES    = 8,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               io_req_valid,
  input  logic [MEMBERS-1:0] io_req_mask,
  output logic               io_req_ready,
  output logic               io_busy,
  output logic [MEMBERS-1:0] auto_out_member_clock,
  output logic [MEMBERS-1:0] auto_out_member_reset
);

  // Counter covers both the hold window and one stagger slot.
  localparam int c_MAX_CNT = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int c_CNT_W   = (c_MAX_CNT > 1) ? $clog2(c_MAX_CNT) : 1;
  localparam int c_SLOT_W  = (MEMBERS > 1) ? $clog2(MEMBERS) : 1;

  localparam logic [c_CNT_W-1:0]  c_HOLD_LAST  = c_CNT_W'(HOLD_CYCLES - 1);
  localparam logic [c_CNT_W-1:0]  c_STAG_LAST  = c_CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [c_SLOT_W-1:0] c_SLOT_LAST  = c_SLOT_W'(MEMBERS - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_IDLE    = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [c_CNT_W-1:0]   cnt_q, cnt_d;
  logic [c_SLOT_W-1:0]  slot_q, slot_d;
  logic [MEMBERS-1:0]   pend_q, pend_d;
  logic [MEMBERS-1:0]   mrst_q, mrst_d;
  logic                 rel_en;

  // The clock is fanned out untouched; there is no gating on member clocks.
  generate
    if (1) begin : g_clock_fanout
      assign auto_out_member_clock = {MEMBERS{clock}};
    end
  endgenerate

  assign auto_out_member_reset = mrst_q;
  assign io_req_ready          = (state_q == ST_IDLE);
  assign io_busy               = ~io_req_ready;

  // State register: reset returns to the full-mask hold with every member in reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      slot_q  <= '0;
      pend_q  <= '1;
      mrst_q  <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      pend_q  <= pend_d;
      mrst_q  <= mrst_d;
    end
  end

  // Next-state: hold, then walk every slot (masked or not) so release times
  // depend only on member index.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    pend_d  = pend_q;
    mrst_d  = mrst_q;
    rel_en  = 1'b0;

    case (state_q)
      ST_ASSERT: begin
        if (cnt_q == c_HOLD_LAST) begin
          // Slot 0 begins on the next cycle, so member 0 is released now.
          state_d = ST_RELEASE;
          cnt_d   = '0;
          slot_d  = '0;
          rel_en  = 1'b1;
        end else begin
          cnt_d = cnt_q + c_CNT_W'(1);
        end
      end

      ST_RELEASE: begin
        if (slot_q == c_SLOT_LAST) begin
          // Ready one cycle after the last slot starts; its remaining
          // stagger cycles are not waited out.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == c_STAG_LAST) begin
          cnt_d  = '0;
          slot_d = slot_q + c_SLOT_W'(1);
          rel_en = 1'b1;
        end else begin
          cnt_d = cnt_q + c_CNT_W'(1);
        end
      end

      ST_IDLE: begin
        // An empty mask is acknowledged but changes nothing.
        if (io_req_valid && (|io_req_mask)) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          slot_d  = '0;
          pend_d  = io_req_mask;
          mrst_d  = mrst_q | io_req_mask;
        end
      end

      default: begin
        state_d = ST_ASSERT;
        cnt_d   = '0;
        slot_d  = '0;
        pend_d  = '1;
        mrst_d  = '1;
      end
    endcase

    // Release the member owning the slot that starts next cycle, if pending.
    if (rel_en) begin
      for (int i = 0; i < MEMBERS; i++) begin
        if ((c_SLOT_W'(i) == slot_d) && pend_q[i]) begin
          mrst_d[i] = 1'b0;
          pend_d[i] = 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_group_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_group_reset_sequencer
// Description : Self-checking bench for clock_group_reset_sequencer. Two
//               instances: default parameters and a 1/1/1 minimal group.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_group_reset_sequencer;

  localparam int M     = 4;
  localparam int H     = 8;
  localparam int S     = 4;
  localparam int END_A = H + (M - 1) * S + 1;
  localparam int END_B = 2;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, valid_a, ready_a, busy_a;
  logic [3:0] mask_a, mclk_a, mrst_a;
  logic       rst_b, valid_b, ready_b, busy_b;
  logic [0:0] mask_b, mclk_b, mrst_b;

  clock_group_reset_sequencer #(.MEMBERS(4), .HOLD_CYCLES(8), .STAGGER_CYCLES(4)) u_dut_a (
    .clock                 (clk),
    .reset                 (rst_a),
    .io_req_valid          (valid_a),
    .io_req_mask           (mask_a),
    .io_req_ready          (ready_a),
    .io_busy               (busy_a),
    .auto_out_member_clock (mclk_a),
    .auto_out_member_reset (mrst_a)
  );

  clock_group_reset_sequencer #(.MEMBERS(1), .HOLD_CYCLES(1), .STAGGER_CYCLES(1)) u_dut_b (
    .clock                 (clk),
    .reset                 (rst_b),
    .io_req_valid          (valid_b),
    .io_req_mask           (mask_b),
    .io_req_ready          (ready_b),
    .io_busy               (busy_b),
    .auto_out_member_clock (mclk_b),
    .auto_out_member_reset (mrst_b)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: relative cycle r since sequence start, active mask,
  // and the member reset values in force before the sequence started.
  int          a_r = 0, b_r = 0;
  logic [15:0] a_mask = 16'hFFFF, a_prev = 16'hFFFF;
  logic [15:0] b_mask = 16'hFFFF, b_prev = 16'hFFFF;

  // Member i of a masked sequence is in reset until r = h + i*s.
  function automatic logic [15:0] f_exp(int r, logic [15:0] m, logic [15:0] p, int h, int s);
    logic [15:0] v;
    for (int i = 0; i < 16; i++)
      v[i] = m[i] ? (r < h + i * s) : p[i];
    return v;
  endfunction

  // Advance one clock and update the model with the inputs that were sampled.
  task automatic step();
    @(posedge clk);
    if (rst_a) begin
      a_r = 0; a_mask = 16'h000F; a_prev = 16'h000F;
    end else if (a_r >= END_A) begin
      if (valid_a && mask_a != 4'd0) begin
        a_prev = f_exp(a_r, a_mask, a_prev, H, S);
        a_mask = {12'd0, mask_a};
        a_r    = 0;
      end
    end else begin
      a_r++;
    end
    if (rst_b) begin
      b_r = 0; b_mask = 16'h0001; b_prev = 16'h0001;
    end else if (b_r >= END_B) begin
      if (valid_b && mask_b != 1'b0) begin
        b_prev = f_exp(b_r, b_mask, b_prev, 1, 1);
        b_mask = {15'd0, mask_b};
        b_r    = 0;
      end
    end else begin
      b_r++;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] e;
    rst_a = 1'b1; valid_a = 1'b0; mask_a = 4'd0;
    rst_b = 1'b1; valid_b = 1'b0; mask_b = 1'b0;
    repeat (3) step();
    total++;
    if (mrst_a !== 4'hF || ready_a !== 1'b0 || busy_a !== 1'b1)
      $display("FAIL reset_state: rst=%h rdy=%b busy=%b expected rst=f rdy=0 busy=1", mrst_a, ready_a, busy_a);
    else passed++;
    rst_a = 1'b0;
    for (int r = 0; r < 25; r++) begin
      e = {r < 20, r < 16, r < 12, r < 8};
      total++;
      if (mrst_a !== e || ready_a !== (r >= 21) || busy_a !== (r < 21))
        $display("FAIL reset_release r=%0d: rst=%h rdy=%b busy=%b expected rst=%h rdy=%b", r, mrst_a, ready_a, busy_a, e, r >= 21);
      else passed++;
      step();
    end
  endtask

  task automatic test_partial_mask();
    logic [15:0] ea;
    valid_a = 1'b1; mask_a = 4'b1010;
    step();
    valid_a = 1'b0; mask_a = 4'd0;
    for (int r = 0; r < 25; r++) begin
      ea = f_exp(a_r, a_mask, a_prev, H, S);
      total++;
      if (mrst_a !== ea[3:0] || ready_a !== (a_r >= END_A))
        $display("FAIL partial_mask r=%0d: rst=%h rdy=%b expected rst=%h rdy=%b", r, mrst_a, ready_a, ea[3:0], a_r >= END_A);
      else passed++;
      total++;
      if (mrst_a[0] !== 1'b0 || mrst_a[2] !== 1'b0)
        $display("FAIL partial_unmasked r=%0d: rst=%h expected bits 0,2 low", r, mrst_a);
      else passed++;
      step();
    end
  endtask

  task automatic test_zero_mask();
    valid_a = 1'b1; mask_a = 4'd0;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (mrst_a !== 4'h0 || ready_a !== 1'b1 || busy_a !== 1'b0)
        $display("FAIL zero_mask k=%0d: rst=%h rdy=%b busy=%b expected rst=0 rdy=1 busy=0", k, mrst_a, ready_a, busy_a);
      else passed++;
    end
    valid_a = 1'b0;
  endtask

  task automatic test_busy_ignore();
    logic [15:0] ea;
    valid_a = 1'b1; mask_a = 4'b0010;
    step();
    valid_a = 1'b0; mask_a = 4'd0;
    for (int r = 0; r < 30; r++) begin
      ea = f_exp(a_r, a_mask, a_prev, H, S);
      total++;
      if (mrst_a !== ea[3:0] || ready_a !== (a_r >= END_A) || mrst_a[0] !== 1'b0)
        $display("FAIL busy_ignore r=%0d: rst=%h rdy=%b expected rst=%h rdy=%b", r, mrst_a, ready_a, ea[3:0], a_r >= END_A);
      else passed++;
      valid_a = (r == 10);
      mask_a  = (r == 10) ? 4'b0001 : 4'd0;
      step();
    end
    valid_a = 1'b0; mask_a = 4'd0;
  endtask

  task automatic test_reset_midseq();
    logic [15:0] ea;
    valid_a = 1'b1; mask_a = 4'b1111;
    step();
    valid_a = 1'b0; mask_a = 4'd0;
    repeat (14) step();
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    total++;
    if (mrst_a !== 4'hF || ready_a !== 1'b0)
      $display("FAIL midseq_reset: rst=%h rdy=%b expected rst=f rdy=0", mrst_a, ready_a);
    else passed++;
    for (int k = 0; k < 23; k++) begin
      ea = f_exp(a_r, a_mask, a_prev, H, S);
      total++;
      if (mrst_a !== ea[3:0] || mrst_a[0] !== (k < 8) || ready_a !== (k >= 21))
        $display("FAIL midseq_restart k=%0d: rst=%h rdy=%b expected rst=%h rdy=%b", k, mrst_a, ready_a, ea[3:0], k >= 21);
      else passed++;
      step();
    end
  endtask

  task automatic test_small_config();
    logic [1:0] tab [6];
    tab[0] = 2'b10; tab[1] = 2'b00; tab[2] = 2'b01;
    tab[3] = 2'b10; tab[4] = 2'b00; tab[5] = 2'b01;
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    // Table entries are {member reset, ready} at r=0,1,2 of two sequences.
    for (int k = 0; k < 6; k++) begin
      total++;
      if ({mrst_b[0], ready_b} !== tab[k] || busy_b !== ~tab[k][0])
        $display("FAIL small_config k=%0d: rst=%b rdy=%b expected rst=%b rdy=%b", k, mrst_b, ready_b, tab[k][1], tab[k][0]);
      else passed++;
      valid_b = (k == 2);
      mask_b  = (k == 2) ? 1'b1 : 1'b0;
      step();
    end
    valid_b = 1'b0; mask_b = 1'b0;
  endtask

  task automatic test_clock_fanout();
    total++;
    if (mclk_a !== 4'hF || mclk_b !== 1'b1)
      $display("FAIL clock_high: a=%h b=%b expected a=f b=1", mclk_a, mclk_b);
    else passed++;
    @(negedge clk); #1;
    total++;
    if (mclk_a !== 4'h0 || mclk_b !== 1'b0)
      $display("FAIL clock_low: a=%h b=%b expected a=0 b=0", mclk_a, mclk_b);
    else passed++;
    step();
  endtask

  task automatic test_random();
    logic [15:0] ea, eb;
    for (int k = 0; k < 400; k++) begin
      ea = f_exp(a_r, a_mask, a_prev, H, S);
      eb = f_exp(b_r, b_mask, b_prev, 1, 1);
      total++;
      if (mrst_a !== ea[3:0] || ready_a !== (a_r >= END_A) || busy_a !== (a_r < END_A))
        $display("FAIL random_a k=%0d: rst=%h rdy=%b expected rst=%h rdy=%b", k, mrst_a, ready_a, ea[3:0], a_r >= END_A);
      else passed++;
      total++;
      if (mrst_b[0] !== eb[0] || ready_b !== (b_r >= END_B))
        $display("FAIL random_b k=%0d: rst=%b rdy=%b expected rst=%b rdy=%b", k, mrst_b, ready_b, eb[0], b_r >= END_B);
      else passed++;
      rst_a   = ($urandom_range(0, 39) == 0);
      valid_a = 1'($urandom_range(0, 1));
      mask_a  = 4'($urandom_range(0, 15));
      rst_b   = ($urandom_range(0, 19) == 0);
      valid_b = 1'($urandom_range(0, 1));
      mask_b  = 1'($urandom_range(0, 1));
      step();
    end
    rst_a = 1'b0; valid_a = 1'b0; mask_a = 4'd0;
    rst_b = 1'b0; valid_b = 1'b0; mask_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_partial_mask();
    test_zero_mask();
    test_busy_ignore();
    test_reset_midseq();
    test_small_config();
    test_clock_fanout();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
